table_search_seq: RTL and testbench

Clocked, parametrised table search engine. It holds a DEPTH-entry table of DATA_W-bit values and, on request, scans it one entry per cycle against a latched key. It supports two modes: first-match with early termination, and count-all-matches. Every entry examined before termination is streamed on a scan port for logging and checking. It is the synthesizable, multi-mode successor to the team's fixed 7-entry behavioural search loop, and sits between a host-side table loader and downstream classification logic.

---
 rtl/table_search_seq.sv | 96 +++++++++
 tb/tb_table_search_seq.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/table_search_seq.sv
// table_search_seq: DEPTH-entry table scanned one entry per cycle in first-match or count-all mode
module table_search_seq #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8,
  parameter int IDX_W  = $clog2(DEPTH),
  parameter int CNT_W  = $clog2(DEPTH + 1)
)(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              start,
  input  logic [DATA_W-1:0] key,
  input  logic              mode,
  output logic              busy,
  output logic              scan_valid,
  output logic [IDX_W-1:0]  scan_idx,
  output logic [DATA_W-1:0] scan_data,
  output logic              done,
  output logic              found,
  output logic [IDX_W-1:0]  match_idx,
  output logic [CNT_W-1:0]  match_cnt
);
  typedef enum logic {IDLE, SCAN} state_t;
  state_t            state;
  logic [DATA_W-1:0] tbl [DEPTH];
  logic [DATA_W-1:0] key_q;
  logic              mode_q;
  logic [IDX_W-1:0]  idx;
  logic [IDX_W-1:0]  first_idx;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  cnt_nx;
  logic              hit;
  logic              last;
  logic              term;
  // compare the current entry; the running count includes this entry
  always_comb begin
    hit    = tbl[idx] == key_q;
    last   = idx == IDX_W'(DEPTH - 1);
    cnt_nx = cnt + CNT_W'(hit);
    term   = (!mode_q && hit) || last;
  end
  // table storage: defaults i+1, host writes land at the edge so a same-cycle compare sees the old value
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) for (int i = 0; i < DEPTH; i++) tbl[i] <= DATA_W'(i + 1);
    else if (wr_en && int'(wr_addr) < DEPTH) tbl[wr_addr] <= wr_data;
  // search FSM with registered scan stream and result outputs
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state      <= IDLE;
      key_q      <= '0;
      mode_q     <= 1'b0;
      idx        <= '0;
      first_idx  <= '0;
      cnt        <= '0;
      busy       <= 1'b0;
      scan_valid <= 1'b0;
      scan_idx   <= '0;
      scan_data  <= '0;
      done       <= 1'b0;
      found      <= 1'b0;
      match_idx  <= '0;
      match_cnt  <= '0;
    end else begin
      scan_valid <= 1'b0;
      done       <= 1'b0;
      if (state == IDLE) begin
        if (start) begin
          state  <= SCAN;
          key_q  <= key;
          mode_q <= mode;
          idx    <= '0;
          cnt    <= '0;
          busy   <= 1'b1;
        end
      end else begin
        if (mode_q || !hit) begin
          scan_valid <= 1'b1;
          scan_idx   <= idx;
          scan_data  <= tbl[idx];
        end
        if (hit && cnt == '0) first_idx <= idx;
        cnt <= cnt_nx;
        idx <= last ? idx : idx + 1'b1;
        if (term) begin
          state     <= IDLE;
          busy      <= 1'b0;
          done      <= 1'b1;
          found     <= cnt_nx != '0;
          match_cnt <= cnt_nx;
          match_idx <= cnt != '0 ? first_idx : (hit ? idx : '0);
        end
      end
    end
endmodule

// File: tb/tb_table_search_seq.sv
// tb_table_search_seq: vector, hand-sequence and randomized checks of table_search_seq
module tb_table_search_seq;
  localparam int DW = 8;
  localparam int D  = 8;
  localparam int IW = 3;
  localparam int CW = 4;
  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          wr_en = 1'b0;
  logic [IW-1:0] wr_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic          start = 1'b0;
  logic [DW-1:0] key = '0;
  logic          mode = 1'b0;
  logic          busy, scan_valid, done, found;
  logic [IW-1:0] scan_idx, match_idx;
  logic [DW-1:0] scan_data;
  logic [CW-1:0] match_cnt;
  int            checks = 0;
  int            errors = 0;
  logic [DW-1:0] ref_tbl [D];
  typedef struct {
    logic [DW-1:0] k;
    logic          m;
    logic          f;
    int            mi, mc, lat, ns;
  } vec_t;
  vec_t vecs [8];

  always #5 clk = ~clk;

  table_search_seq #(.DATA_W(DW), .DEPTH(D)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .start(start), .key(key), .mode(mode), .busy(busy), .scan_valid(scan_valid),
    .scan_idx(scan_idx), .scan_data(scan_data), .done(done), .found(found),
    .match_idx(match_idx), .match_cnt(match_cnt)
  );

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d", n, act, exp);
    end
  endtask

  task automatic ref_reset();
    for (int i = 0; i < D; i++) ref_tbl[i] = DW'(i + 1);
  endtask

  // reference: derived from the list of matching indices, not from any cycle behaviour
  task automatic model(input logic [DW-1:0] k, input logic m, output logic f,
                       output int mi, output int mc, output int lat, output int ns);
    int q[$];
    for (int i = 0; i < D; i++) if (ref_tbl[i] == k) q.push_back(i);
    f  = q.size() > 0;
    mi = f ? q[0] : 0;
    if (!m && f) begin
      mc = 1; lat = q[0] + 1; ns = q[0];
    end else begin
      mc = m ? q.size() : 0; lat = D; ns = D;
    end
  endtask

  task automatic wr(input int a, input int d);
    @(negedge clk);
    wr_en = 1'b1; wr_addr = IW'(a); wr_data = DW'(d);
    @(posedge clk); #1;
    wr_en = 1'b0;
    ref_tbl[a] = DW'(d);
  endtask

  task automatic wait_done(input int c0, output int lat);
    lat = -1;
    for (int c = c0 + 1; c <= c0 + D + 4; c++) begin
      @(posedge clk); #1;
      if (done) begin
        lat = c;
        break;
      end
    end
  endtask

  task automatic run_search(input logic [DW-1:0] k, input logic m, input logic ef,
                            input int ei, input int ec, input int el, input int en);
    int n = 0;
    int lat = -1;
    @(negedge clk);
    start = 1'b1; key = k; mode = m;
    @(posedge clk); #1;
    start = 1'b0;
    chk("busy_after_start", busy, 1);
    for (int c = 1; c <= D + 4; c++) begin
      @(posedge clk); #1;
      if (scan_valid) begin
        chk("scan_idx", scan_idx, n);
        chk("scan_data", scan_data, (n < D) ? ref_tbl[n] : 0);
        n++;
      end
      if (done) begin
        lat = c;
        break;
      end
    end
    chk("latency", lat, el);
    chk("scan_count", n, en);
    chk("found", found, ef);
    chk("match_idx", match_idx, ei);
    chk("match_cnt", match_cnt, ec);
    chk("busy_at_done", busy, 0);
    @(posedge clk); #1;
    chk("done_one_cycle", done, 0);
  endtask

  initial begin
    int lat;
    logic f;
    int mi, mc, el, en;
    vecs[0] = '{8'd2, 1'b0, 1'b1, 1, 1, 2, 1};
    vecs[1] = '{8'd1, 1'b0, 1'b1, 0, 1, 1, 0};
    vecs[2] = '{8'd9, 1'b0, 1'b0, 0, 0, 8, 8};
    vecs[3] = '{8'd8, 1'b1, 1'b1, 7, 1, 8, 8};
    vecs[4] = '{8'd8, 1'b0, 1'b1, 7, 1, 8, 7};
    vecs[5] = '{8'd0, 1'b1, 1'b0, 0, 0, 8, 8};
    vecs[6] = '{8'd5, 1'b1, 1'b1, 2, 3, 8, 8};
    vecs[7] = '{8'd5, 1'b0, 1'b1, 2, 1, 3, 2};
    ref_reset();
    #2 rst_n = 1'b0;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_scan_valid", scan_valid, 0);
    chk("rst_found", found, 0);
    chk("rst_match_idx", match_idx, 0);
    chk("rst_match_cnt", match_cnt, 0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      if (i == 6) begin
        wr(2, 5);
        wr(6, 5);
      end
      run_search(vecs[i].k, vecs[i].m, vecs[i].f, vecs[i].mi, vecs[i].mc, vecs[i].lat, vecs[i].ns);
    end

    // start during SCAN with another key is ignored; table is 1,2,5,4,5,6,5,8
    @(negedge clk); start = 1'b1; key = 8'd5; mode = 1'b0;
    @(posedge clk); #1;
    @(negedge clk); start = 1'b1; key = 8'd3; mode = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(1, lat);
    chk("ignored_start_lat", lat, 3);
    chk("ignored_start_found", found, 1);
    chk("ignored_start_idx", match_idx, 2);
    chk("ignored_start_cnt", match_cnt, 1);
    // back-to-back start in the done cycle
    @(negedge clk); start = 1'b1; key = 8'd1; mode = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    chk("b2b_busy", busy, 1);
    chk("b2b_hold_idx", match_idx, 2);
    @(posedge clk); #1;
    chk("b2b_done", done, 1);
    chk("b2b_match_idx", match_idx, 0);
    chk("b2b_match_cnt", match_cnt, 1);

    // writes during scan: same-cycle entry uses old value, later entry uses new value
    @(negedge clk); start = 1'b1; key = 8'hAA; mode = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk); wr_en = 1'b1; wr_addr = 3'd0; wr_data = 8'hAA;
    @(posedge clk); #1;
    chk("wr_same_scan_valid", scan_valid, 1);
    chk("wr_same_scan_data", scan_data, 1);
    @(negedge clk); wr_addr = 3'd4;
    @(posedge clk); #1;
    wr_en = 1'b0;
    ref_tbl[0] = 8'hAA;
    ref_tbl[4] = 8'hAA;
    wait_done(2, lat);
    chk("wr_ahead_lat", lat, 5);
    chk("wr_ahead_idx", match_idx, 4);
    chk("wr_ahead_found", found, 1);

    // asynchronous reset in the middle of a miss search
    @(negedge clk); start = 1'b1; key = 8'd99; mode = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_found", found, 0);
    chk("abort_scan_valid", scan_valid, 0);
    ref_reset();
    lat = 0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      if (done) lat++;
    end
    @(negedge clk) rst_n = 1'b1;
    for (int c = 0; c < D; c++) begin
      @(posedge clk); #1;
      if (done || busy) lat++;
    end
    chk("abort_no_done", lat, 0);
    run_search(8'd3, 1'b0, 1'b1, 2, 1, 3, 2);

    // randomized table contents and searches against the reference
    for (int r = 0; r < 40; r++) begin
      for (int w = 0; w < int'($urandom_range(0, 2)); w++)
        wr(int'($urandom_range(0, D - 1)), int'($urandom_range(0, 12)));
      key  = DW'($urandom_range(0, 12));
      mode = 1'($urandom_range(0, 1));
      model(key, mode, f, mi, mc, el, en);
      run_search(key, mode, f, mi, mc, el, en);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
